zrle_flex: RTL

- Parametrised zero run-length encoder for the EBPC encoder path.
- Consumes one binary symbol per cycle (is_one_i) and packs variable-length codes MSB-first into DATA_W-bit output words.
- Adds two features: a runtime raw-bitmap bypass mode, and a per-block output word counter.
- Sits between the zero-detection front end and the stream packer.

---
 rtl/ebpc_pkg.sv | 36 +++
 rtl/zrle_flex_if.sv | 24 ++
 rtl/bit_accumulator.sv | 56 +++++
 rtl/zrle_flex.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ebpc_pkg.sv
// rtl/ebpc_pkg.sv - shared types and helpers for the EBPC encoder path
package ebpc_pkg;

  typedef enum logic [2:0] {
    EMPTY,
    FILLING,
    FULL,
    FLUSH_ZEROS,
    FLUSH
  } state_t;

  localparam logic ZRLE_MODE_ENC = 1'b0;
  localparam logic ZRLE_MODE_RAW = 1'b1;

  // CODE_NONE: nothing is appended this cycle (a zero that only extends the run)
  typedef enum logic [2:0] {
    CODE_NONE,
    CODE_ONE,
    CODE_RUN,
    CODE_MAX,
    CODE_FZ,
    CODE_RAW
  } code_kind_t;

  // Width in bits of the code a symbol (or trailing run) produces
  function automatic int unsigned zrle_code_len(logic mode, code_kind_t kind, int unsigned len_w);
    if (kind == CODE_NONE) return 0;
    if (mode != ZRLE_MODE_ENC) return 1;
    case (kind)
      CODE_ONE: return 1;
      CODE_RUN: return len_w + 2;
      default:  return len_w + 1;
    endcase
  endfunction

endpackage

// File: rtl/zrle_flex_if.sv
// rtl/zrle_flex_if.sv - symbol input and word output handshakes of zrle_flex
interface zrle_flex_if #(
  parameter int DATA_W = 8
);
  logic              mode_i;
  logic              vld_i;
  logic              rdy_o;
  logic              is_one_i;
  logic              flush_i;
  logic [DATA_W-1:0] data_o;
  logic              last_o;
  logic              vld_o;
  logic              rdy_i;

  modport slave (
    input  mode_i, vld_i, is_one_i, flush_i, rdy_i,
    output rdy_o, data_o, last_o, vld_o
  );

  modport master (
    output mode_i, vld_i, is_one_i, flush_i, rdy_i,
    input  rdy_o, data_o, last_o, vld_o
  );
endinterface

// File: rtl/bit_accumulator.sv
// rtl/bit_accumulator.sv - 2*DATA_W MSB-first bit packer with shift counter
module bit_accumulator #(
  parameter int DATA_W = 8,
  parameter int CODE_W = 6,
  parameter int SC_W   = 5,
  parameter int LN_W   = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                pop_i,
  input  logic                sub_i,
  input  logic                app_en_i,
  input  logic [CODE_W-1:0]   code_i,
  input  logic [LN_W-1:0]     len_i,
  output logic [2*DATA_W-1:0] acc_o,
  output logic [SC_W-1:0]     shift_cnt_o,
  output logic                full_o
);
  localparam int ACC_W = 2 * DATA_W;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] shifted;
  logic [ACC_W-1:0] aligned;
  logic [SC_W-1:0]  cnt_q;
  logic [SC_W-1:0]  sum;
  logic [LN_W-1:0]  pad;

  // Post-append bit count and the code moved to its MSB-first slot; after a pop the
  // remaining bits sit at the top, so the write offset is still the stored count
  always_comb begin
    sum     = cnt_q + (app_en_i ? SC_W'(len_i) : '0);
    full_o  = (sum >= SC_W'(DATA_W));
    shifted = pop_i ? (acc_q << DATA_W) : acc_q;
    pad     = LN_W'(CODE_W) - len_i;
    aligned = ({code_i, {(ACC_W - CODE_W){1'b0}}} << pad) >> cnt_q;
  end

  // Clear wins; otherwise pop first, then OR the new code in
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= app_en_i ? (shifted | aligned) : shifted;
      cnt_q <= sub_i ? (sum - SC_W'(DATA_W)) : sum;
    end
  end

  assign acc_o       = acc_q;
  assign shift_cnt_o = cnt_q;

endmodule

// File: rtl/zrle_flex.sv
// rtl/zrle_flex.sv - zero run-length encoder with raw bypass and per-block word count
module zrle_flex
  import ebpc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  zrle_flex_if.slave       bus,
  output logic             idle_o,
  output logic [CNT_W-1:0] word_cnt_o
);
  localparam int CODE_W = LEN_W + 2;
  localparam int SC_W   = $clog2(2 * DATA_W + 1);
  localparam int LN_W   = $clog2(CODE_W + 1);
  // Longest run a single code can describe (MAX_RUN-1)
  localparam logic [LEN_W-1:0] RUN_MAX = {LEN_W{1'b1}};

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    zero_cnt_q, zero_cnt_d, run_m1;
  logic                mode_q, blk_q, eff_mode;
  logic [CNT_W-1:0]    word_cnt_q;
  code_kind_t          kind;
  logic [CODE_W-1:0]   code;
  logic [LN_W-1:0]     len;
  logic                accept, hs, last, sub, clear, full;
  logic [2*DATA_W-1:0] acc;
  logic [SC_W-1:0]     shift_cnt;

  bit_accumulator #(
    .DATA_W (DATA_W),
    .CODE_W (CODE_W),
    .SC_W   (SC_W),
    .LN_W   (LN_W)
  ) u_acc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear),
    .pop_i       (hs),
    .sub_i       (sub),
    .app_en_i    (kind != CODE_NONE),
    .code_i      (code),
    .len_i       (len),
    .acc_o       (acc),
    .shift_cnt_o (shift_cnt),
    .full_o      (full)
  );

  assign bus.rdy_o  = (state_q == EMPTY) || (state_q == FILLING) || ((state_q == FULL) && bus.rdy_i);
  assign bus.vld_o  = (state_q == FULL) || (state_q == FLUSH);
  assign last       = (state_q == FLUSH) && (shift_cnt <= SC_W'(DATA_W));
  assign bus.last_o = last;
  assign bus.data_o = acc[2*DATA_W-1 -: DATA_W];
  assign accept     = bus.vld_i && bus.rdy_o;
  assign hs         = bus.vld_o && bus.rdy_i;
  // The first symbol of a block sees mode_i directly; the rest use the latched copy
  assign eff_mode   = blk_q ? mode_q : bus.mode_i;
  assign run_m1     = zero_cnt_q - LEN_W'(1);
  assign idle_o     = (state_q == EMPTY) && !bus.vld_i;
  assign word_cnt_o = word_cnt_q;

  // Choose the code for this cycle (accepted symbol or trailing run) and track pending zeros
  always_comb begin
    kind       = CODE_NONE;
    code       = '0;
    zero_cnt_d = zero_cnt_q;
    if (state_q == FLUSH_ZEROS) begin
      kind       = CODE_FZ;
      code       = {2'b00, run_m1};
      zero_cnt_d = '0;
    end else if (accept) begin
      if (eff_mode == ZRLE_MODE_RAW) begin
        kind = CODE_RAW;
        code = CODE_W'(bus.is_one_i);
      end else if (bus.is_one_i) begin
        zero_cnt_d = '0;
        if (zero_cnt_q == '0) begin
          kind = CODE_ONE;
          code = CODE_W'(1);
        end else begin
          kind = CODE_RUN;
          code = {1'b0, run_m1, 1'b1};
        end
      end else if (zero_cnt_q == RUN_MAX) begin
        kind       = CODE_MAX;
        code       = {2'b00, RUN_MAX};
        zero_cnt_d = '0;
      end else begin
        zero_cnt_d = zero_cnt_q + LEN_W'(1);
      end
    end
    len = LN_W'(zrle_code_len(eff_mode, kind, LEN_W));
  end

  // Next-state decode; FULL entry and non-final FLUSH pops knock DATA_W off the count
  always_comb begin
    state_d = state_q;
    sub     = 1'b0;
    clear   = 1'b0;
    case (state_q)
      EMPTY, FILLING, FULL: begin
        if (accept) begin
          if (bus.flush_i) begin
            state_d = (zero_cnt_d != '0) ? FLUSH_ZEROS : FLUSH;
          end else if (full) begin
            state_d = FULL;
            sub     = 1'b1;
          end else begin
            state_d = FILLING;
          end
        end else if ((state_q == FULL) && hs) begin
          state_d = (shift_cnt == '0) ? EMPTY : FILLING;
        end
      end
      FLUSH_ZEROS: state_d = FLUSH;
      FLUSH: begin
        if (hs) begin
          if (last) begin
            state_d = EMPTY;
            clear   = 1'b1;
          end else begin
            sub = 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, run counter, block/mode latch and saturating word counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      zero_cnt_q <= '0;
      mode_q     <= ZRLE_MODE_ENC;
      blk_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      if (accept && !blk_q) mode_q <= bus.mode_i;
      if (accept) blk_q <= 1'b1;
      else if (clear) blk_q <= 1'b0;
      // The final count stays visible for one idle cycle before clearing
      if (hs) begin
        if (word_cnt_q != '1) word_cnt_q <= word_cnt_q + CNT_W'(1);
      end else if ((state_q == EMPTY) && !blk_q) begin
        word_cnt_q <= '0;
      end
    end
  end

  // Nothing may linger in the datapath while the encoder sits in EMPTY
  assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == EMPTY) |-> ((acc == '0) && (shift_cnt == '0) && (zero_cnt_q == '0)));

endmodule
